ahbl_fabric_dec: RTL and testbench
==================================

// Module: ahbl_fabric_dec
// PURPOSE
//  Parametrised AHB-Lite data fabric: one master (core data port) to NUM_SLV slaves.
//  Decodes address phase by base/mask table, registers data-phase select, muxes responses.
//  Adds an internal default slave (two-cycle ERROR on unmapped access).
//  Adds a per-transfer wait-state watchdog that aborts hung slaves and quarantines them.
// PARAMETERS
//  NUM_SLV      16            number of slave ports (1..32)
//  ADDR_WIDTH   32            address width (system_pkg value)
//  DATA_WIDTH   32            data width (system_pkg value)
//  SLV_BASE     system_pkg    [NUM_SLV][ADDR_WIDTH] region base addresses
//  SLV_MASK     system_pkg    [NUM_SLV][ADDR_WIDTH] region masks; hit = (haddr & MASK) == BASE
//  TIMEOUT_CYC  256           max wait states per data phase; 0 disables watchdog
// PORTS
//  clk             in   1                  fabric clock
//  rstn            in   1                  asynchronous active-low reset
//  ahbl_haddr      in   ADDR_WIDTH         master address
//  ahbl_hburst     in   3                  master burst, broadcast
//  ahbl_hmastlock  in   1                  master lock, broadcast
//  ahbl_hprot      in   4                  master prot, broadcast
//  ahbl_hsize      in   3                  master size, broadcast
//  ahbl_htrans     in   2                  master trans, broadcast
//  ahbl_hwdata     in   DATA_WIDTH         master write data, broadcast
//  ahbl_hwrite     in   1                  master write, broadcast
//  ahbl_hrdata     out  DATA_WIDTH         muxed read data
//  ahbl_hready     out  1                  muxed ready; also driven to every slave as s_hready
//  ahbl_hresp      out  1                  muxed response (0 OKAY, 1 ERROR)
//  s_hsel          out  NUM_SLV            one-hot address-phase select
//  s_hready        out  1                  HREADY input to all slaves (= ahbl_hready)
//  s_hrdata        in   NUM_SLV*DATA_WIDTH per-slave read data
//  s_hreadyout     in   NUM_SLV            per-slave ready
//  s_hresp         in   NUM_SLV            per-slave response
//  timeout_o       out  1                  one-cycle pulse on watchdog abort
//  err_addr_o      out  ADDR_WIDTH         address of last ERROR transfer (unmapped or timeout)
//  quarantine_o    out  NUM_SLV            sticky mask of aborted slaves
// BEHAVIOUR
//  Reset (async): dsel=none, FSM IDLE, wdog=0, quarantine_o=0, err_addr_o=0, timeout_o=0.
//   Outputs during reset: ahbl_hready=1, ahbl_hresp=0, ahbl_hrdata=0.
//  Decode (combinational): active = htrans[1]. s_hsel[i] = active & hit[i] & ~quarantine[i].
//   Lowest index wins on overlap. No hit or quarantined -> default slave.
//  Data-phase select: dsel <= {slave idx | DEFAULT | NONE}, updated only when ahbl_hready=1.
//   IDLE/BUSY transfers load NONE.
//  Response mux: dsel=i -> s_hreadyout[i], s_hresp[i], s_hrdata[i].
//   NONE -> hready=1, hresp=0, hrdata=0. DEFAULT -> default-slave FSM outputs, hrdata=0.
//  Default-slave FSM: IDLE -> ERR1 (hready=0, hresp=1) -> ERR2 (hready=1, hresp=1).
//   ERR2 -> ERR1 if another DEFAULT access is captured, else IDLE.
//   err_addr_o latches haddr at capture.
//  Watchdog: wdog counts cycles with dsel=i and s_hreadyout[i]=0; cleared when ahbl_hready=1.
//   Width $clog2(TIMEOUT_CYC+1). On wdog==TIMEOUT_CYC-1:
//   - pulse timeout_o;
//   - set quarantine_o[i];
//   - err_addr_o <= data-phase address;
//   - force FSM to ERR1; dsel <= DEFAULT.
//   Slave i outputs are ignored thereafter; only rstn clears quarantine.
//  Master drops htrans to IDLE during ERR1: legal. Next captured transfer is IDLE -> NONE.
//  Simultaneous timeout and new address phase: impossible (hready=0).
//   Address held by master is re-decoded after ERR2.
//  hwdata and control are broadcast unregistered; no added latency. Zero-wait OKAY slave -> 0 wait.
// STRUCTURE
//  system_pkg gains:
//   - htrans_e (IDLE/BUSY/NONSEQ/SEQ);
//   - HRESP_OKAY/HRESP_ERROR;
//   - AHBL_NUM_SLV;
//   - AHBL_SLV_BASE/AHBL_SLV_MASK tables.
//  Sub-module ahbl_default_slave: ERR1/ERR2 FSM with inputs sel_i, force_err_i, hready_i.
// TESTING
//  Map slave 3 at 0x0003_0000/0xFFFF_0000; NONSEQ read 0x0003_0010, slave hrdata=0xCAFE
//   -> s_hsel=0x0008, master sees 0xCAFE next cycle, hresp=0.
//  NONSEQ to unmapped 0x8000_0000 -> hready 0,1 with hresp 1,1; err_addr_o=0x8000_0000.
//  Back-to-back unmapped NONSEQ+SEQ -> ERR1,ERR2,ERR1,ERR2; no OKAY between.
//  TIMEOUT_CYC=8; slave 5 holds hreadyout=0 -> timeout_o pulses at wait 8.
//   -> ERROR pair; quarantine_o[5]=1; next access to slave 5 -> default ERROR, s_hsel=0.
//  Overlapping regions 1 and 2 -> only s_hsel[1]; IDLE/BUSY never assert s_hsel.
//  rstn low mid ERR1 and mid watchdog count -> outputs at reset values immediately;
//   quarantine cleared.

Source files
------------

// File: rtl/ahbl_fabric_dec_pkg.sv
// Shared AHB-Lite fabric types: transfer encodings, response codes, default region map
// and the state encodings used by the data-phase select and the default slave.
package ahbl_fabric_dec_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int AHBL_NUM_SLV    = 16;
    localparam int AHBL_ADDR_WIDTH = 32;
    localparam int AHBL_DATA_WIDTH = 32;

    // Default map: slave i owns the 64 KiB window at i << 16.
    function automatic logic [AHBL_NUM_SLV-1:0][AHBL_ADDR_WIDTH-1:0] ahbl_region_base();
        logic [AHBL_NUM_SLV-1:0][AHBL_ADDR_WIDTH-1:0] t;
        for (int i = 0; i < AHBL_NUM_SLV; i++) begin
            t[i] = AHBL_ADDR_WIDTH'(i) << 16;
        end
        return t;
    endfunction

    localparam logic [AHBL_NUM_SLV-1:0][AHBL_ADDR_WIDTH-1:0] AHBL_SLV_BASE = ahbl_region_base();
    localparam logic [AHBL_NUM_SLV-1:0][AHBL_ADDR_WIDTH-1:0] AHBL_SLV_MASK =
        {AHBL_NUM_SLV{32'hFFFF_0000}};

    typedef enum logic [1:0] {
        DSEL_NONE = 2'd0,
        DSEL_DEF  = 2'd1,
        DSEL_SLV  = 2'd2
    } dsel_e;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } dslv_state_e;

endpackage

// File: rtl/ahbl_fabric_dec_default_slave.sv
// Internal default slave: answers unmapped or aborted transfers with the two-cycle
// AHB-Lite ERROR response. Outputs are registered alongside the state.
module ahbl_default_slave
    import ahbl_fabric_dec_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        sel_i,
    input  logic        force_err_i,
    input  logic        hready_i,
    output logic        hready_o,
    output logic        hresp_o,
    output dslv_state_e state_o
);

    dslv_state_e state_q;
    logic        hready_q;
    logic        hresp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= DS_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
        end else if (force_err_i) begin
            state_q  <= DS_ERR1;
            hready_q <= 1'b0;
            hresp_q  <= HRESP_ERROR;
        end else begin
            case (state_q)
                DS_IDLE: begin
                    if (hready_i && sel_i) begin
                        state_q  <= DS_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_ERROR;
                    end
                end
                DS_ERR1: begin
                    state_q  <= DS_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                DS_ERR2: begin
                    // hready is high here, so the pending address phase is captured now.
                    if (hready_i && sel_i) begin
                        state_q  <= DS_ERR1;
                        hready_q <= 1'b0;
                        hresp_q  <= HRESP_ERROR;
                    end else begin
                        state_q  <= DS_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
                default: begin
                    state_q  <= DS_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign hready_o = hready_q;
    assign hresp_o  = hresp_q;
    assign state_o  = state_q;

endmodule

// File: rtl/ahbl_fabric_dec.sv
// AHB-Lite one-master fabric: base/mask address decode, registered data-phase select,
// response mux, internal default slave and a wait-state watchdog that quarantines slaves.
module ahbl_fabric_dec
    import ahbl_fabric_dec_pkg::*;
#(
    parameter int NUM_SLV     = AHBL_NUM_SLV,
    parameter int ADDR_WIDTH  = AHBL_ADDR_WIDTH,
    parameter int DATA_WIDTH  = AHBL_DATA_WIDTH,
    parameter logic [NUM_SLV-1:0][ADDR_WIDTH-1:0] SLV_BASE = AHBL_SLV_BASE,
    parameter logic [NUM_SLV-1:0][ADDR_WIDTH-1:0] SLV_MASK = AHBL_SLV_MASK,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [ADDR_WIDTH-1:0]         ahbl_haddr,
    input  logic [2:0]                    ahbl_hburst,
    input  logic                          ahbl_hmastlock,
    input  logic [3:0]                    ahbl_hprot,
    input  logic [2:0]                    ahbl_hsize,
    input  logic [1:0]                    ahbl_htrans,
    input  logic [DATA_WIDTH-1:0]         ahbl_hwdata,
    input  logic                          ahbl_hwrite,
    output logic [DATA_WIDTH-1:0]         ahbl_hrdata,
    output logic                          ahbl_hready,
    output logic                          ahbl_hresp,
    output logic [NUM_SLV-1:0]            s_hsel,
    output logic                          s_hready,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] s_hrdata,
    input  logic [NUM_SLV-1:0]            s_hreadyout,
    input  logic [NUM_SLV-1:0]            s_hresp,
    output logic                          timeout_o,
    output logic [ADDR_WIDTH-1:0]         err_addr_o,
    output logic [NUM_SLV-1:0]            quarantine_o
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYC > 0);
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;

    dsel_e                 dsel_q, dsel_d;
    logic [IDX_W-1:0]      dsel_idx_q, dsel_idx_d;
    logic [ADDR_WIDTH-1:0] daddr_q, daddr_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;
    logic [NUM_SLV-1:0]    quar_q, quar_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

    logic             active;
    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_slv;
    logic             dec_def;
    logic             slv_waiting;
    logic             abort;
    logic             def_hready;
    logic             def_hresp;
    dslv_state_e      def_state;

    // Control and write data reach the slaves straight from the master bus.
    logic unused_bcast;
    assign unused_bcast = ^{ahbl_hburst, ahbl_hmastlock, ahbl_hprot, ahbl_hsize,
                            ahbl_hwdata, ahbl_hwrite, ahbl_htrans[0], def_state};

    assign active = ahbl_htrans[1];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((ahbl_haddr & SLV_MASK[i]) == SLV_BASE[i]) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
        dec_slv = active && dec_hit && !quar_q[dec_idx];
        dec_def = active && !dec_slv;
        s_hsel  = '0;
        if (dec_slv) begin
            s_hsel[dec_idx] = 1'b1;
        end
    end

    always_comb begin
        ahbl_hready = 1'b1;
        ahbl_hresp  = HRESP_OKAY;
        ahbl_hrdata = '0;
        case (dsel_q)
            DSEL_DEF: begin
                ahbl_hready = def_hready;
                ahbl_hresp  = def_hresp;
            end
            DSEL_SLV: begin
                ahbl_hready = s_hreadyout[dsel_idx_q];
                ahbl_hresp  = s_hresp[dsel_idx_q];
                ahbl_hrdata = s_hrdata[dsel_idx_q*DATA_WIDTH +: DATA_WIDTH];
            end
            default: ;
        endcase
    end

    assign s_hready    = ahbl_hready;
    assign slv_waiting = (dsel_q == DSEL_SLV) && !s_hreadyout[dsel_idx_q];
    assign abort       = WD_EN && slv_waiting && (wdog_q == WD_LAST);

    always_comb begin
        dsel_d     = dsel_q;
        dsel_idx_d = dsel_idx_q;
        daddr_d    = daddr_q;
        wdog_d     = wdog_q;
        quar_d     = quar_q;
        err_addr_d = err_addr_q;
        if (abort) begin
            // Hand the stuck data phase to the default slave to finish with ERROR.
            dsel_d             = DSEL_DEF;
            wdog_d             = '0;
            quar_d[dsel_idx_q] = 1'b1;
            err_addr_d         = daddr_q;
        end else if (ahbl_hready) begin
            wdog_d     = '0;
            dsel_idx_d = dec_idx;
            daddr_d    = ahbl_haddr;
            if (dec_slv) begin
                dsel_d = DSEL_SLV;
            end else if (dec_def) begin
                dsel_d     = DSEL_DEF;
                err_addr_d = ahbl_haddr;
            end else begin
                dsel_d = DSEL_NONE;
            end
        end else if (WD_EN && slv_waiting) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dsel_q     <= DSEL_NONE;
            dsel_idx_q <= '0;
            daddr_q    <= '0;
            wdog_q     <= '0;
            quar_q     <= '0;
            err_addr_q <= '0;
        end else begin
            dsel_q     <= dsel_d;
            dsel_idx_q <= dsel_idx_d;
            daddr_q    <= daddr_d;
            wdog_q     <= wdog_d;
            quar_q     <= quar_d;
            err_addr_q <= err_addr_d;
        end
    end

    ahbl_default_slave u_default_slave (
        .clk         (clk),
        .rstn        (rstn),
        .sel_i       (dec_def),
        .force_err_i (abort),
        .hready_i    (ahbl_hready),
        .hready_o    (def_hready),
        .hresp_o     (def_hresp),
        .state_o     (def_state)
    );

    assign timeout_o    = abort;
    assign err_addr_o   = err_addr_q;
    assign quarantine_o = quar_q;

endmodule

// File: tb/tb_ahbl_fabric_dec.sv
// Directed bench for ahbl_fabric_dec: decode, response mux, default-slave ERROR pairs,
// watchdog abort with quarantine, and asynchronous reset in the middle of activity.
module tb_ahbl_fabric_dec;

    localparam int NS = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    // Slave 2 deliberately overlaps slave 1's window.
    localparam logic [NS-1:0][AW-1:0] TB_BASE = {
        32'h0007_0000, 32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
        32'h0003_0000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    localparam logic [NS-1:0][AW-1:0] TB_MASK = {NS{32'hFFFF_0000}};

    logic              clk;
    logic              rstn;
    logic [AW-1:0]     haddr;
    logic [1:0]        htrans;
    logic [DW-1:0]     hwdata;
    logic              hwrite;
    logic [DW-1:0]     hrdata;
    logic              hready;
    logic              hresp;
    logic [NS-1:0]     s_hsel;
    logic              s_hready;
    logic [NS*DW-1:0]  s_hrdata;
    logic [NS-1:0]     s_hreadyout;
    logic [NS-1:0]     s_hresp;
    logic              timeout;
    logic [AW-1:0]     err_addr;
    logic [NS-1:0]     quar;

    int n_cmp = 0;
    int n_err = 0;

    ahbl_fabric_dec #(
        .NUM_SLV     (NS),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .SLV_BASE    (TB_BASE),
        .SLV_MASK    (TB_MASK),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ahbl_haddr     (haddr),
        .ahbl_hburst    (3'b000),
        .ahbl_hmastlock (1'b0),
        .ahbl_hprot     (4'b0011),
        .ahbl_hsize     (3'b010),
        .ahbl_htrans    (htrans),
        .ahbl_hwdata    (hwdata),
        .ahbl_hwrite    (hwrite),
        .ahbl_hrdata    (hrdata),
        .ahbl_hready    (hready),
        .ahbl_hresp     (hresp),
        .s_hsel         (s_hsel),
        .s_hready       (s_hready),
        .s_hrdata       (s_hrdata),
        .s_hreadyout    (s_hreadyout),
        .s_hresp        (s_hresp),
        .timeout_o      (timeout),
        .err_addr_o     (err_addr),
        .quarantine_o   (quar)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL time_limit got=expired exp=finished");
        $fatal(1, "time limit");
    end

    // Checking
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_resp(input string tag, input logic exp_rdy, input logic exp_resp);
        check_val({tag, "_hready"}, 32'(hready), 32'(exp_rdy));
        check_val({tag, "_hresp"}, 32'(hresp), 32'(exp_resp));
        check_val({tag, "_s_hready"}, 32'(s_hready), 32'(exp_rdy));
    endtask

    // Driver: inputs change 1 ns after the rising edge, checks land 4 ns later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [1:0] t);
        haddr  = a;
        htrans = t;
    endtask

    initial begin
        rstn        = 1'b0;
        hwdata      = 32'h1234_5678;
        hwrite      = 1'b0;
        s_hreadyout = '1;
        s_hresp     = '0;
        for (int i = 0; i < NS; i++) s_hrdata[i*DW +: DW] = 32'hD000_0000 | 32'(i);
        s_hrdata[3*DW +: DW] = 32'h0000_CAFE;
        drive(32'h0, 2'b00);

        // Reset values
        #12;
        check_resp("rst", 1'b1, 1'b0);
        check_val("rst_hrdata", hrdata, 32'h0);
        check_val("rst_quar", 32'(quar), 32'h0);
        check_val("rst_err_addr", err_addr, 32'h0);
        check_val("rst_timeout", 32'(timeout), 32'h0);
        #11;
        rstn = 1'b1;
        cyc();

        // Mapped read from slave 3, zero wait states
        drive(32'h0003_0010, 2'b10);
        #4 check_val("rd3_hsel", 32'(s_hsel), 32'h08);
        cyc();
        drive(32'h0, 2'b00);
        #4 check_resp("rd3", 1'b1, 1'b0);
        check_val("rd3_hrdata", hrdata, 32'h0000_CAFE);
        check_val("rd3_hsel_idle", 32'(s_hsel), 32'h0);

        // Overlap priority and non-active transfers
        cyc();
        drive(32'h0001_0100, 2'b10);
        #2 check_val("ovl_hsel", 32'(s_hsel), 32'h02);
        drive(32'h0003_0010, 2'b01);
        #1 check_val("busy_hsel", 32'(s_hsel), 32'h0);
        drive(32'h0003_0010, 2'b00);
        #1 check_val("idle_hsel", 32'(s_hsel), 32'h0);
        cyc();
        #4 check_resp("none", 1'b1, 1'b0);
        check_val("none_hrdata", hrdata, 32'h0);

        // Single unmapped access
        cyc();
        drive(32'h8000_0000, 2'b10);
        #4 check_val("unm_hsel", 32'(s_hsel), 32'h0);
        cyc();
        drive(32'h0, 2'b00);
        #4 check_resp("unm_err1", 1'b0, 1'b1);
        cyc();
        #4 check_resp("unm_err2", 1'b1, 1'b1);
        check_val("unm_err_addr", err_addr, 32'h8000_0000);
        check_val("unm_hrdata", hrdata, 32'h0);
        cyc();
        #4 check_resp("unm_done", 1'b1, 1'b0);

        // Back-to-back unmapped NONSEQ then SEQ
        drive(32'h8000_0000, 2'b10);
        cyc();
        drive(32'h8000_0004, 2'b11);
        #4 check_resp("b2b_err1a", 1'b0, 1'b1);
        cyc();
        #4 check_resp("b2b_err2a", 1'b1, 1'b1);
        cyc();
        drive(32'h0, 2'b00);
        #4 check_resp("b2b_err1b", 1'b0, 1'b1);
        cyc();
        #4 check_resp("b2b_err2b", 1'b1, 1'b1);
        check_val("b2b_err_addr", err_addr, 32'h8000_0004);
        cyc();
        #4 check_resp("b2b_done", 1'b1, 1'b0);

        // Watchdog: slave 5 never becomes ready; master holds a slave-3 address meanwhile
        drive(32'h0005_0000, 2'b10);
        s_hreadyout[5] = 1'b0;
        #4 check_val("wd_hsel", 32'(s_hsel), 32'h20);
        cyc();
        drive(32'h0003_0020, 2'b10);
        for (int k = 1; k <= TO; k++) begin
            #4;
            check_val($sformatf("wd_timeout_w%0d", k), 32'(timeout), 32'(k == TO));
            check_val($sformatf("wd_hready_w%0d", k), 32'(hready), 32'h0);
            cyc();
        end
        #4 check_resp("wd_err1", 1'b0, 1'b1);
        check_val("wd_timeout_after", 32'(timeout), 32'h0);
        check_val("wd_quar", 32'(quar), 32'h20);
        check_val("wd_err_addr", err_addr, 32'h0005_0000);
        cyc();
        #4 check_resp("wd_err2", 1'b1, 1'b1);
        check_val("wd_redecode_hsel", 32'(s_hsel), 32'h08);
        cyc();
        drive(32'h0, 2'b00);
        #4 check_resp("wd_next3", 1'b1, 1'b0);
        check_val("wd_next3_hrdata", hrdata, 32'h0000_CAFE);

        // Quarantined slave 5 now answered by the default slave
        cyc();
        drive(32'h0005_0040, 2'b10);
        #4 check_val("q5_hsel", 32'(s_hsel), 32'h0);
        cyc();
        drive(32'h0, 2'b00);
        #4 check_resp("q5_err1", 1'b0, 1'b1);
        cyc();
        #4 check_resp("q5_err2", 1'b1, 1'b1);
        check_val("q5_err_addr", err_addr, 32'h0005_0040);
        check_val("q5_quar", 32'(quar), 32'h20);
        cyc();

        // Reset in the middle of ERR1
        drive(32'h8000_0000, 2'b10);
        cyc();
        drive(32'h0, 2'b00);
        #1 rstn = 1'b0;
        #1 check_resp("rst_err1", 1'b1, 1'b0);
        check_val("rst_err1_quar", 32'(quar), 32'h0);
        check_val("rst_err1_err_addr", err_addr, 32'h0);
        cyc();
        #2 rstn = 1'b1;
        cyc();

        // Reset in the middle of a watchdog count
        drive(32'h0005_0000, 2'b10);
        #4 check_val("rst_wd_hsel", 32'(s_hsel), 32'h20);
        cyc();
        drive(32'h0, 2'b00);
        cyc();
        cyc();
        #1 check_val("rst_wd_hready_pre", 32'(hready), 32'h0);
        rstn = 1'b0;
        #1 check_resp("rst_wd", 1'b1, 1'b0);
        check_val("rst_wd_timeout", 32'(timeout), 32'h0);
        check_val("rst_wd_hrdata", hrdata, 32'h0);
        cyc();
        #2 rstn = 1'b1;

        // After reset slave 5 is reachable again and read with zero waits
        s_hreadyout[5] = 1'b1;
        cyc();
        drive(32'h0005_0008, 2'b10);
        cyc();
        drive(32'h0, 2'b00);
        #4 check_resp("post_rd5", 1'b1, 1'b0);
        check_val("post_rd5_hrdata", hrdata, 32'hD000_0005);
        check_val("post_quar", 32'(quar), 32'h0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
